wb_pattern_master: RTL and testbench

Synthesizable Wishbone classic single-cycle bus master. It sits directly downstream of the system clock/reset generator and drives the SSRAM interface slave under test.
- On a start pulse it writes NUM_WORDS pseudo-random words from an LFSR, then reads them back and compares them.
- It reports busy, done, pass, an error count, and the address of the first failure.
- It serves as a self-checking traffic source for bench and FPGA bring-up.

---
 rtl/wb_pattern_pkg.sv | 22 ++
 rtl/wb_pattern_master_lfsr.sv | 22 ++
 rtl/wb_pattern_master.sv | 178 +++++++++++++++++
 tb/tb_wb_pattern_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pattern_pkg.sv
// Shared types and constants for the Wishbone pattern master and its LFSR.
package wb_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_GAP,
    ST_RD,
    ST_RD_GAP,
    ST_DONE
  } state_e;

  // Feedback taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [3:0]  SEL_ALL   = 4'hF;
  localparam int          ERR_CNT_W = 16;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {q[30:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wb_pattern_master_lfsr.sv
// 32-bit Fibonacci LFSR; the same instance replays the sequence for write and read phases.
module wb_lfsr32
  import wb_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/wb_pattern_master.sv
// Wishbone classic master: writes NUM_WORDS LFSR words, reads them back and
// reports failures (mismatch, err_i, or timeout).
module wb_pattern_master
  import wb_pattern_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           NUM_WORDS  = 256,
  parameter logic [31:0]           SEED       = 32'hACE1_2468,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  we_o,
  output logic [3:0]            sel_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = 16;

  state_e                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_entry_idx;
  logic [TMO_W-1:0]        r_tmo;
  logic [ADDR_WIDTH-1:0]   r_adr, r_first;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_we, r_cyc, r_busy, r_done, r_pass;
  logic [3:0]              r_sel;
  logic [ERR_CNT_W-1:0]    r_err_cnt, w_err_inc;
  logic [31:0]             w_lfsr_q;
  logic                    w_ack, w_err, w_tmo, w_complete, w_last;
  logic                    w_start_acc, w_enter, w_fail, w_lfsr_load;

  // Slave responses only count while our own cycle is open.
  assign w_ack       = r_cyc & ack_i;
  assign w_err       = r_cyc & err_i;
  assign w_tmo       = r_cyc & (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_complete  = w_ack | w_err | w_tmo;
  assign w_last      = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign w_start_acc = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_lfsr_load = w_start_acc | ((r_state == ST_WR) & w_complete & w_last);
  assign w_err_inc   = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;

  wb_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (w_lfsr_load),
    .seed (SEED),
    .step (w_complete),
    .q    (w_lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_fail      = 1'b0;
    w_entry_idx = r_idx;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_WR;
          w_enter     = 1'b1;
          w_entry_idx = '0;
        end
      end
      ST_WR: begin
        if (w_complete) begin
          w_fail      = ~w_ack;
          w_state_nxt = w_last ? ST_RD_GAP : ST_WR_GAP;
        end
      end
      ST_WR_GAP: begin
        w_state_nxt = ST_WR;
        w_enter     = 1'b1;
      end
      ST_RD: begin
        if (w_complete) begin
          w_fail      = w_ack ? (dat_i != w_lfsr_q) : 1'b1;
          w_state_nxt = w_last ? ST_DONE : ST_RD_GAP;
        end
      end
      ST_RD_GAP: begin
        w_state_nxt = ST_RD;
        w_enter     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_tmo     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_cyc     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err_cnt <= '0;
      r_first   <= '0;
    end else begin
      if (w_enter) begin
        r_cyc <= 1'b1;
        r_sel <= SEL_ALL;
        r_we  <= (w_state_nxt == ST_WR);
        r_adr <= BASE_ADDR + (ADDR_WIDTH'(w_entry_idx) << 2);
        r_tmo <= '0;
        // On a fresh start the LFSR is reloaded this same edge, so take SEED directly.
        if (w_state_nxt == ST_WR) r_dat <= w_start_acc ? SEED : w_lfsr_q;
      end else if (r_cyc) begin
        if (w_complete) begin
          r_cyc <= 1'b0;
          r_sel <= '0;
          r_we  <= 1'b0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end

      if (w_start_acc) begin
        r_idx     <= '0;
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_pass    <= 1'b0;
        r_err_cnt <= '0;
        r_first   <= '0;
      end

      if (w_complete) r_idx <= w_last ? '0 : r_idx + 1'b1;

      if (w_fail) begin
        if (r_err_cnt == '0) r_first <= r_adr;
        r_err_cnt <= w_err_inc;
      end

      if ((r_state == ST_RD) && (w_state_nxt == ST_DONE)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (r_err_cnt == '0) & ~w_fail;
      end
    end
  end

  assign adr_o          = r_adr;
  assign dat_o          = r_dat;
  assign we_o           = r_we;
  assign sel_o          = r_sel;
  assign cyc_o          = r_cyc;
  assign stb_o          = r_cyc;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_cnt;
  assign first_err_addr = r_first;

endmodule

// File: tb/tb_wb_pattern_master.sv
// Randomized self-checking bench: configurable fault-injecting memory slave plus
// a transaction-level reference model of the expected pass.
module tb_wb_pattern_master;

  localparam int          NW     = 4;
  localparam int          TMO    = 15;
  localparam logic [31:0] SEED_P = 32'hACE1_2468;

  logic        clk, rst, start;
  logic [31:0] adr_o, dat_o, dat_i, first_err_addr;
  logic        we_o, cyc_o, stb_o, ack_i, err_i, busy, done, pass;
  logic [3:0]  sel_o;
  logic [15:0] err_count;

  wb_pattern_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (32'h0),
    .NUM_WORDS  (NW),
    .SEED       (SEED_P),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .adr_o          (adr_o),
    .dat_o          (dat_o),
    .dat_i          (dat_i),
    .we_o           (we_o),
    .sel_o          (sel_o),
    .cyc_o          (cyc_o),
    .stb_o          (stb_o),
    .ack_i          (ack_i),
    .err_i          (err_i),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Slave fault knobs: nak = never respond, errr = err_i on read, both = ack+err, flip = bit0 on read.
  bit          nak_en, flip_en, errr_en, both_en;
  logic [31:0] nak_a, flip_a, errr_a, both_a;
  int          wt_w[NW], wt_r[NW];
  logic [31:0] mem[16];
  int          wc;

  logic [1:0]  s_idx;
  int          s_wait;
  logic        s_go, s_nak, s_errr;

  always_comb begin
    s_idx  = adr_o[3:2];
    s_wait = we_o ? wt_w[s_idx] : wt_r[s_idx];
    s_go   = cyc_o && stb_o && (wc == s_wait);
    s_nak  = nak_en && (adr_o == nak_a);
    s_errr = !we_o && errr_en && (adr_o == errr_a);
    ack_i  = s_go && !s_nak && !s_errr;
    err_i  = s_go && !s_nak && (s_errr || (both_en && (adr_o == both_a)));
    dat_i  = mem[adr_o[5:2]] ^ ((!we_o && flip_en && (adr_o == flip_a)) ? 32'h1 : 32'h0);
  end

  always @(posedge clk) begin
    if (rst || !cyc_o) wc <= 0;
    else               wc <= wc + 1;
    if (cyc_o && stb_o && we_o && ack_i) mem[adr_o[5:2]] <= dat_o;
  end

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          len;
  } txn_t;

  txn_t log_q[$];
  txn_t cur;
  bit   in_txn;

  always @(posedge clk) begin
    if (rst) begin
      in_txn <= 1'b0;
    end else if (cyc_o) begin
      if (!in_txn) begin
        cur.adr <= adr_o;
        cur.we  <= we_o;
        cur.dat <= dat_o;
        cur.len <= 1;
        in_txn  <= 1'b1;
      end else begin
        cur.len <= cur.len + 1;
      end
    end else if (in_txn) begin
      log_q.push_back(cur);
      in_txn <= 1'b0;
    end
  end

  function automatic logic [31:0] ref_word(input int i);
    logic [31:0] q = SEED_P;
    repeat (i) q = {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
    return q;
  endfunction

  task automatic set_clean();
    nak_en = 0; flip_en = 0; errr_en = 0; both_en = 0;
    nak_a = 0; flip_a = 0; errr_a = 0; both_a = 0;
    for (int i = 0; i < NW; i++) begin wt_w[i] = 0; wt_r[i] = 0; end
  endtask

  task automatic set_random();
    nak_en  = ($urandom_range(0, 3) == 0); nak_a  = 32'($urandom_range(0, NW - 1) * 4);
    flip_en = ($urandom_range(0, 2) == 0); flip_a = 32'($urandom_range(0, NW - 1) * 4);
    errr_en = ($urandom_range(0, 3) == 0); errr_a = 32'($urandom_range(0, NW - 1) * 4);
    both_en = ($urandom_range(0, 2) == 0); both_a = 32'($urandom_range(0, NW - 1) * 4);
    for (int i = 0; i < NW; i++) begin
      wt_w[i] = $urandom_range(0, 3);
      wt_r[i] = $urandom_range(0, 3);
    end
  endtask

  task automatic run_pass(input string name, input bit mid_start);
    txn_t        exp_q[$];
    int          exp_err = 0, exp_edges = 0, k = 0;
    logic [31:0] exp_first = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < NW; i++) begin
        txn_t        t;
        bit          nk, fl;
        logic [31:0] a = 32'(i * 4);
        nk    = nak_en && (a == nak_a);
        t.adr = a;
        t.we  = (ph == 0);
        t.dat = ref_word(i);
        t.len = nk ? TMO : ((ph == 0 ? wt_w[i] : wt_r[i]) + 1);
        if (ph == 0) fl = nk;
        else fl = nk || (errr_en && a == errr_a) || (flip_en && a == flip_a);
        if (fl) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
        exp_edges += t.len;
        exp_q.push_back(t);
      end
    end
    exp_edges += 2 * NW - 1;

    log_q.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({name, ":busy_after_start"}, busy, 1);
    check({name, ":done_cleared"}, done, 0);
    check({name, ":pass_cleared"}, pass, 0);
    check({name, ":err_cleared"}, err_count, 0);
    check({name, ":first_cleared"}, first_err_addr, 0);
    check({name, ":cyc_stb_first"}, {cyc_o, stb_o, we_o, sel_o}, 7'b111_1111);
    check({name, ":first_adr_dat"}, adr_o ^ dat_o, SEED_P);

    while (!done && k < 1000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start = mid_start && (k == 4);
    end
    start = 1'b0;
    check({name, ":done_seen"}, done, 1);
    check({name, ":edges_to_done"}, k, exp_edges);
    check({name, ":err_count"}, err_count, exp_err);
    check({name, ":first_err_addr"}, first_err_addr, exp_first);
    check({name, ":pass"}, pass, (exp_err == 0));
    check({name, ":busy_end"}, busy, 0);

    @(posedge clk);
    @(negedge clk);
    check({name, ":done_held"}, done, 1);
    check({name, ":bus_idle"}, {cyc_o, stb_o, sel_o}, 0);
    check({name, ":txn_count"}, log_q.size(), 2 * NW);
    for (int i = 0; i < 2 * NW && i < log_q.size(); i++) begin
      check($sformatf("%s:t%0d_adr", name, i), log_q[i].adr, exp_q[i].adr);
      check($sformatf("%s:t%0d_we", name, i), log_q[i].we, exp_q[i].we);
      check($sformatf("%s:t%0d_len", name, i), log_q[i].len, exp_q[i].len);
      if (exp_q[i].we) check($sformatf("%s:t%0d_dat", name, i), log_q[i].dat, exp_q[i].dat);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ":bus"}, {cyc_o, stb_o, we_o, sel_o}, 0);
    check({name, ":adr_dat"}, adr_o | dat_o, 0);
    check({name, ":status"}, {busy, done, pass}, 0);
    check({name, ":errs"}, err_count | first_err_addr, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_clean();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("idle_no_start");

    set_clean();
    run_pass("clean", 1'b0);

    set_clean(); flip_en = 1; flip_a = 32'h8;
    run_pass("flip8", 1'b0);

    set_clean(); nak_en = 1; nak_a = 32'h4;
    run_pass("timeout4", 1'b0);

    set_clean(); errr_en = 1; errr_a = 32'hC; both_en = 1; both_a = 32'h0;
    run_pass("err_and_both", 1'b0);

    set_clean();
    run_pass("start_while_busy", 1'b1);

    set_clean(); flip_en = 1; flip_a = 32'h0;
    run_pass("failing", 1'b0);
    set_clean();
    run_pass("restart_from_done", 1'b0);

    // Abort during the second write, then confirm a clean recovery.
    set_clean();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort:in_second_write", {cyc_o, we_o, adr_o[7:0]}, {2'b11, 8'h04});
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    check_all_zero("abort_idle");
    run_pass("after_abort", 1'b0);

    for (int r = 0; r < 12; r++) begin
      set_random();
      run_pass($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
